// File: rtl/fft_sample_demux_1x16_if.sv
// Streaming bus for the 1-to-16 sample demux: serial sample input and parallel frame output.
// The master modport is the upstream/downstream side, and the slave modport is the demux itself.
interface fft_sample_demux_1x16_if #(
   parameter int DW = 16
);
   logic              s_valid;
   logic              s_ready;
   logic [DW-1:0]     s_data;
   logic              s_last;
   logic              m_valid;
   logic              m_ready;
   logic [16*DW-1:0]  m_data;

   modport master (
      output s_valid, s_data, s_last, m_ready,
      input  s_ready, m_valid, m_data
   );

   modport slave (
      input  s_valid, s_data, s_last, m_ready,
      output s_ready, m_valid, m_data
   );
endinterface

// File: rtl/fft_sample_demux_1x16.sv
// Collects serial samples into a 16-lane parallel frame and hands it downstream.
// A frame that ends early is padded with zeros and flagged, and a new frame can start on the edge where the old one is consumed.
module fft_sample_demux_1x16 #(
   parameter int DW = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   fft_sample_demux_1x16_if.slave    bus,
   output logic [15:0]               lane_sel,
   output logic                      err_short
);

   typedef enum logic {FILL, HOLD} state_t;

   state_t              state, state_next;
   logic [3:0]          cnt, cnt_next, wr_idx;
   logic                err_next;
   logic                accept, consume, short_close;
   logic [15:0][DW-1:0] frame_buf;

   assign bus.s_ready = (state == FILL) ? 1'b1 : bus.m_ready;
   assign bus.m_valid = (state == HOLD);
   assign bus.m_data  = frame_buf;

   assign accept  = bus.s_valid && bus.s_ready;
   assign consume = bus.m_valid && bus.m_ready;
   // A sample taken while HOLD drains is the first sample of the next frame.
   assign wr_idx      = (state == HOLD) ? 4'd0 : cnt;
   assign short_close = accept && bus.s_last && (wr_idx != 4'd15);

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      err_next   = 1'b0;
      case (state)
         FILL: begin
            if (accept) begin
               if (cnt == 4'd15) begin
                  state_next = HOLD;
                  cnt_next   = 4'd0;
               end else if (bus.s_last) begin
                  state_next = HOLD;
                  cnt_next   = 4'd0;
                  err_next   = 1'b1;
               end else begin
                  cnt_next   = cnt + 4'd1;
               end
            end
         end
         HOLD: begin
            if (consume) begin
               if (accept && bus.s_last) begin
                  state_next = HOLD;
                  cnt_next   = 4'd0;
                  err_next   = 1'b1;
               end else if (accept) begin
                  state_next = FILL;
                  cnt_next   = 4'd1;
               end else begin
                  state_next = FILL;
                  cnt_next   = 4'd0;
               end
            end
         end
         default: begin
            state_next = FILL;
            cnt_next   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= FILL;
         cnt       <= 4'd0;
         lane_sel  <= 16'h0001;
         err_short <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         lane_sel  <= 16'h0001 << cnt_next;
         err_short <= err_next;
      end
   end

   // On an early close, the lanes above the last written one are cleared so stale data never leaks out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_buf <= '0;
      end else if (accept) begin
         for (int k = 0; k < 16; k++) begin
            if (4'(k) == wr_idx)
               frame_buf[k] <= bus.s_data;
            else if (short_close && (4'(k) > wr_idx))
               frame_buf[k] <= '0;
         end
      end
   end

endmodule

// File: tb/tb_fft_sample_demux_1x16.sv
// Directed bench for fft_sample_demux_1x16 covering full, short, wrap-closed and back-to-back frames.
// It also covers backpressure and a reset applied mid-frame.
module tb_fft_sample_demux_1x16;

   localparam int DW = 16;
   localparam int FW = 16 * DW;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] lane_sel;
   logic        err_short;
   int          err_count;
   int          check_count;

   always #5 clk = ~clk;

   fft_sample_demux_1x16_if #(.DW(DW)) bus ();

   fft_sample_demux_1x16 #(.DW(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .lane_sel  (lane_sel),
      .err_short (err_short)
   );

   task automatic checkOutput(input string tag, input logic [FW-1:0] observed,
                              input logic [FW-1:0] expected);
      check_count++;
      if (observed !== expected) begin
         err_count++;
         $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic l,
                                input logic mr);
      bus.s_valid = v;
      bus.s_data  = d;
      bus.s_last  = l;
      bus.m_ready = mr;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected frame: lanes 0..n-1 count up from base, remaining lanes zero.
   function automatic logic [FW-1:0] ramp(input logic [DW-1:0] base, input int n);
      logic [FW-1:0] f;
      f = '0;
      for (int k = 0; k < n; k++)
         f[k*DW +: DW] = base + DW'(k);
      return f;
   endfunction

   initial begin
      err_count   = 0;
      check_count = 0;
      rst         = 1'b1;
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      repeat (2) tick();
      checkOutput("rst_s_ready",   bus.s_ready, 1);
      checkOutput("rst_m_valid",   bus.m_valid, 0);
      checkOutput("rst_m_data",    bus.m_data,  0);
      checkOutput("rst_lane_sel",  lane_sel,    16'h0001);
      checkOutput("rst_err_short", err_short,   0);
      rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, DW'(i), 1'b0, 1'b1);
         checkOutput("full_lane_sel", lane_sel, 16'h0001 << i);
         checkOutput("full_s_ready", bus.s_ready, 1);
         tick();
      end
      checkOutput("full_m_valid",   bus.m_valid, 1);
      checkOutput("full_m_data",    bus.m_data,  ramp(16'h0000, 16));
      checkOutput("full_lane_wrap", lane_sel,    16'h0001);
      checkOutput("full_err_short", err_short,   0);

      applyStimulus(1'b1, 16'hB000, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         checkOutput("bp_s_ready", bus.s_ready, 0);
         checkOutput("bp_m_valid", bus.m_valid, 1);
         checkOutput("bp_m_data",  bus.m_data,  ramp(16'h0000, 16));
         tick();
      end
      applyStimulus(1'b1, 16'hB000, 1'b0, 1'b1);
      checkOutput("bp_release_s_ready", bus.s_ready, 1);
      tick();
      checkOutput("bp_zb_m_valid",  bus.m_valid,        0);
      checkOutput("bp_zb_lane0",    bus.m_data[DW-1:0], 16'hB000);
      checkOutput("bp_zb_lane_sel", lane_sel,           16'h0002);
      for (int i = 1; i < 16; i++) begin
         applyStimulus(1'b1, DW'(32'hB000 + i), 1'b0, 1'b1);
         tick();
      end
      checkOutput("bp_frame2_m_valid", bus.m_valid, 1);
      checkOutput("bp_frame2_m_data",  bus.m_data,  ramp(16'hB000, 16));
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      tick();
      checkOutput("drain_m_valid",  bus.m_valid, 0);
      checkOutput("drain_lane_sel", lane_sel,    16'h0001);

      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, DW'(32'hA000 + i), (i == 4), 1'b0);
         tick();
      end
      checkOutput("short_m_valid",   bus.m_valid, 1);
      checkOutput("short_err_short", err_short,   1);
      checkOutput("short_m_data",    bus.m_data,  ramp(16'hA000, 5));
      checkOutput("short_lane_sel",  lane_sel,    16'h0001);
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      tick();
      checkOutput("short_err_once", err_short,   0);
      checkOutput("short_hold",     bus.m_valid, 1);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      tick();

      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, DW'(32'hC000 + i), (i == 15), 1'b0);
         tick();
      end
      checkOutput("wrap_m_valid",   bus.m_valid, 1);
      checkOutput("wrap_err_short", err_short,   0);
      checkOutput("wrap_m_data",    bus.m_data,  ramp(16'hC000, 16));

      for (int i = 0; i < 48; i++) begin
         applyStimulus(1'b1, DW'(32'hD000 + i), 1'b0, 1'b1);
         checkOutput("b2b_s_ready", bus.s_ready, 1);
         tick();
         if (i % 16 == 15) begin
            checkOutput("b2b_m_valid", bus.m_valid, 1);
            checkOutput("b2b_m_data",  bus.m_data,  ramp(DW'(32'hD000 + 16 * (i / 16)), 16));
         end else begin
            checkOutput("b2b_m_valid_fill", bus.m_valid, 0);
         end
      end

      applyStimulus(1'b1, 16'hE000, 1'b1, 1'b1);
      tick();
      checkOutput("zbshort_m_valid",   bus.m_valid, 1);
      checkOutput("zbshort_err_short", err_short,   1);
      checkOutput("zbshort_m_data",    bus.m_data,  ramp(16'hE000, 1));
      checkOutput("zbshort_lane_sel",  lane_sel,    16'h0001);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      tick();
      checkOutput("zbshort_drain", bus.m_valid, 0);

      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b1, DW'(32'hF000 + i), 1'b0, 1'b1);
         tick();
      end
      checkOutput("mid_lane_sel", lane_sel, 16'h0080);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("async_rst_lane_sel", lane_sel,    16'h0001);
      checkOutput("async_rst_m_valid",  bus.m_valid, 0);
      checkOutput("async_rst_m_data",   bus.m_data,  0);
      checkOutput("async_rst_s_ready",  bus.s_ready, 1);
      tick();
      rst = 1'b0;
      tick();
      checkOutput("post_rst_no_valid", bus.m_valid, 0);
      checkOutput("post_rst_lane_sel", lane_sel,    16'h0001);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, DW'(32'h1000 + i), 1'b0, 1'b1);
         tick();
         checkOutput("post_rst_m_valid", bus.m_valid, (i == 15));
      end
      checkOutput("post_rst_m_data", bus.m_data, ramp(16'h1000, 16));

      $display("Result: errors=%0d of %0d checks", err_count, check_count);
      $finish;
   end

endmodule
